// File: rtl/jtvigil_pkg.sv
// jtvigil_pkg: shared constants and types for the Vigilante colour mixer.
//   - layer codes: upper two bits of the 9-bit palette index
//   - bank codes: upper two bits of the CPU palette address
//   - rgb_t: one 15-bit palette entry (three 5-bit channels)
//   - opaque(): transparency test on a pixel's low colour nibble
package jtvigil_pkg;

    localparam int COLW = 5;

    localparam logic [1:0] LYR_SCR1 = 2'd0;
    localparam logic [1:0] LYR_OBJ  = 2'd1;
    localparam logic [1:0] LYR_SCR2 = 2'd2;

    localparam logic [1:0] BANK_R    = 2'd0;
    localparam logic [1:0] BANK_G    = 2'd1;
    localparam logic [1:0] BANK_B    = 2'd2;
    localparam logic [1:0] BANK_NONE = 2'd3;

    // A pixel whose low nibble equals this value lets the layer below show through.
    localparam logic [3:0] TRANSP_NIB = 4'h0;

    typedef struct packed {
        logic [COLW-1:0] r;
        logic [COLW-1:0] g;
        logic [COLW-1:0] b;
    } rgb_t;

    function automatic logic opaque(input logic [3:0] nib);
        return nib != TRANSP_NIB;
    endfunction

endpackage

// File: rtl/jtvigil_colmix_if.sv
// jtvigil_colmix_if: CPU palette access bus of the colour mixer.
//   cpu_addr [10:0] {bank[1:0], index[8:0]}; bank 0=R, 1=G, 2=B, 3=unmapped
//   cpu_dout [7:0]  write data, bits [4:0] stored
//   pal_cs          access request
//   cpu_wrn         0=write, 1=read
//   cpu_din  [7:0]  read data {3'b0, value}, 8'h00 for bank 3
//   cpu_ok          access complete
//
// Handshake: the master raises pal_cs with cpu_addr/cpu_wrn/cpu_dout stable and
// holds all of them until cpu_ok is seen high. cpu_ok (and cpu_din for reads)
// then stays valid until the master drops pal_cs; the slave returns cpu_ok low
// one clock later. Dropping pal_cs before cpu_ok abandons the access.
interface jtvigil_colmix_if;

    logic [10:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        pal_cs;
    logic        cpu_wrn;
    logic [7:0]  cpu_din;
    logic        cpu_ok;

    modport master (
        output cpu_addr, cpu_dout, pal_cs, cpu_wrn,
        input  cpu_din, cpu_ok
    );

    modport slave (
        input  cpu_addr, cpu_dout, pal_cs, cpu_wrn,
        output cpu_din, cpu_ok
    );

endinterface

// File: rtl/jtvigil_pal_ram.sv
// jtvigil_pal_ram: single-port 512x15 palette RAM.
//   clk, rst_n   clock / async active-low reset (read register only)
//   addr         entry index
//   we[2:0]      per-bank write enables (bit = bank code R/G/B)
//   wdata        5-bit channel value written to every enabled bank
//   re           read enable; rdata loads the addressed entry on the next edge
//   rdata        registered read data, holds between reads
module jtvigil_pal_ram
    import jtvigil_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   addr,
    input  logic [2:0]      we,
    input  logic [COLW-1:0] wdata,
    input  logic            re,
    output rgb_t            rdata
);

    localparam int DEPTH = 1 << AW;

    logic [COLW-1:0] mem_r [DEPTH];
    logic [COLW-1:0] mem_g [DEPTH];
    logic [COLW-1:0] mem_b [DEPTH];

    rgb_t rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we[BANK_R]) mem_r[addr] <= wdata;
        if (we[BANK_G]) mem_g[addr] <= wdata;
        if (we[BANK_B]) mem_b[addr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d.r = mem_r[addr];
            rdata_d.g = mem_g[addr];
            rdata_d.b = mem_b[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/jtvigil_colmix.sv
// jtvigil_colmix: final video stage. Resolves scroll-2 / scroll-1 / object
// priority, looks the winning pixel up in the CPU-written palette and emits
// registered 5-bit RGB with blanking delayed to match.
//   clk, rst_n         clock / async active-low reset
//   pxl_cen            pixel clock enable
//   lhbl, lvbl         active-low blanking, aligned with pixel inputs
//   scr1_pxl[7:0]      [7] priority over objects, [6:0] colour
//   scr2_pxl[3:0]      scroll-2 colour, always opaque
//   obj_pxl[6:0]       object colour
//   gfx_en[2:0]        layer enables (only with JTVIGIL_LAYER_DEBUG_EN defined)
//   cpu                CPU palette bus (jtvigil_colmix_if.slave)
//   red/green/blue     colour output
//   LHBL, LVBL         blanking delayed by LAT pxl_cen ticks
//   dbg_state          CPU access FSM state
// Build option: JTVIGIL_LAYER_DEBUG_EN adds gfx_en; without it every layer is on.
module jtvigil_colmix
    import jtvigil_pkg::*;
#(
    parameter int PALW = 9,
    parameter int LAT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        lhbl,
    input  logic        lvbl,
    input  logic [7:0]  scr1_pxl,
    input  logic [3:0]  scr2_pxl,
    input  logic [6:0]  obj_pxl,
`ifdef JTVIGIL_LAYER_DEBUG_EN
    input  logic [2:0]  gfx_en,
`endif
    jtvigil_colmix_if.slave cpu,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue,
    output logic        LHBL,
    output logic        LVBL,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [2:0] layer_en;
`ifdef JTVIGIL_LAYER_DEBUG_EN
    assign layer_en = gfx_en;
`else
    assign layer_en = 3'b111;
`endif

    // ---------------- stage 1: priority ----------------
    logic            scr1_op, obj_op;
    logic [PALW-1:0] pick;
    logic [PALW-1:0] idx_d, idx_q;
    logic [LAT-1:0]  hb_d, hb_q, vb_d, vb_q;

    always_comb begin
        scr1_op = layer_en[LYR_SCR1] && opaque(scr1_pxl[3:0]);
        obj_op  = layer_en[LYR_OBJ]  && opaque(obj_pxl[3:0]);
        if (obj_op && !(scr1_op && scr1_pxl[7]))
            pick = {LYR_OBJ, obj_pxl};
        else if (scr1_op)
            pick = {LYR_SCR1, scr1_pxl[6:0]};
        else if (layer_en[LYR_SCR2])
            pick = {LYR_SCR2, 3'd0, scr2_pxl};
        else
            pick = {LYR_SCR2, 7'd0};
        idx_d = pxl_cen ? pick : idx_q;
        // Blanking shift line: [0] pairs with idx_q, [1] with the RAM read, [LAT-1] is the output.
        hb_d  = pxl_cen ? {hb_q[LAT-2:0], lhbl} : hb_q;
        vb_d  = pxl_cen ? {vb_q[LAT-2:0], lvbl} : vb_q;
    end

    // ---------------- arbitration ----------------
    // Video only needs the RAM on the tick that moves a visible pixel into stage 2.
    logic vid_rd, cpu_free;
    assign vid_rd   = pxl_cen && hb_q[0] && vb_q[0];
    assign cpu_free = !vid_rd;

    // ---------------- CPU FSM ----------------
    logic [1:0] st_d, st_q;
    logic [1:0] cpu_bank;
    logic       cpu_go;
    logic [7:0] din_d, din_q;
    rgb_t       ram_q;

    assign cpu_bank = cpu.cpu_addr[10:9];
    // The RAM operation is issued on the WAIT->ACCESS edge, which is always a free cycle.
    assign cpu_go   = (st_q == ST_WAIT) && cpu.pal_cs && cpu_free;

    always_comb begin
        st_d  = st_q;
        din_d = din_q;
        case (st_q)
            ST_IDLE:   if (cpu.pal_cs) st_d = ST_WAIT;
            ST_WAIT: begin
                if (!cpu.pal_cs)   st_d = ST_IDLE;
                else if (cpu_free) st_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                st_d = ST_DONE;
                if (cpu.cpu_wrn) begin
                    case (cpu_bank)
                        BANK_R:  din_d = {3'b000, ram_q.r};
                        BANK_G:  din_d = {3'b000, ram_q.g};
                        BANK_B:  din_d = {3'b000, ram_q.b};
                        default: din_d = 8'h00;
                    endcase
                end
            end
            default:   if (!cpu.pal_cs) st_d = ST_IDLE;
        endcase
    end

    assign cpu.cpu_ok  = (st_q == ST_DONE);
    assign cpu.cpu_din = din_q;
    assign dbg_state   = st_q;

    // ---------------- palette RAM ----------------
    logic [PALW-1:0] ram_addr;
    logic [2:0]      ram_we;
    logic            ram_re;

    assign ram_addr = vid_rd ? idx_q : cpu.cpu_addr[PALW-1:0];
    assign ram_we   = (cpu_go && !cpu.cpu_wrn && cpu_bank != BANK_NONE)
                      ? (3'b001 << cpu_bank) : 3'b000;
    assign ram_re   = vid_rd || (cpu_go && cpu.cpu_wrn);

    logic unused_dout;
    assign unused_dout = &{1'b0, cpu.cpu_dout[7:5]};

    jtvigil_pal_ram #(.AW(PALW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (cpu.cpu_dout[COLW-1:0]),
        .re    (ram_re),
        .rdata (ram_q)
    );

    // ---------------- stage 2 hold / stage 3 output ----------------
    // A CPU read between pixel ticks overwrites the RAM read register, so the
    // video colour is copied into col2 one clock after its lookup. col2_d is
    // the stage-2 colour whether or not that copy has happened yet.
    logic vid_pend_d, vid_pend_q;
    rgb_t col2_d, col2_q;
    rgb_t rgb_d, rgb_q;

    always_comb begin
        vid_pend_d = vid_rd;
        col2_d     = vid_pend_q ? ram_q : col2_q;
        rgb_d      = rgb_q;
        if (pxl_cen)
            rgb_d = (hb_q[1] && vb_q[1]) ? col2_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            hb_q       <= '0;
            vb_q       <= '0;
            st_q       <= ST_IDLE;
            din_q      <= '0;
            vid_pend_q <= 1'b0;
            col2_q     <= '0;
            rgb_q      <= '0;
        end else begin
            idx_q      <= idx_d;
            hb_q       <= hb_d;
            vb_q       <= vb_d;
            st_q       <= st_d;
            din_q      <= din_d;
            vid_pend_q <= vid_pend_d;
            col2_q     <= col2_d;
            rgb_q      <= rgb_d;
        end
    end

    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;
    assign LHBL  = hb_q[LAT-1];
    assign LVBL  = vb_q[LAT-1];

endmodule

// File: tb/tb_jtvigil_colmix.sv
`timescale 1ns/1ps
module tb_jtvigil_colmix;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       lhbl = 1'b0;
    logic       lvbl = 1'b0;
    logic [7:0] scr1_pxl = 8'h00;
    logic [3:0] scr2_pxl = 4'h0;
    logic [6:0] obj_pxl = 7'h00;
`ifdef JTVIGIL_LAYER_DEBUG_EN
    logic [2:0] gfx_en = 3'b111;
`endif
    logic [4:0] red, green, blue;
    logic       LHBL, LVBL;
    logic [1:0] dbg_state;

    jtvigil_colmix_if bus();

    jtvigil_colmix dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .lhbl      (lhbl),
        .lvbl      (lvbl),
        .scr1_pxl  (scr1_pxl),
        .scr2_pxl  (scr2_pxl),
        .obj_pxl   (obj_pxl),
`ifdef JTVIGIL_LAYER_DEBUG_EN
        .gfx_en    (gfx_en),
`endif
        .cpu       (bus),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .LHBL      (LHBL),
        .LVBL      (LVBL),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] rgb_now();
        return {red, green, blue};
    endfunction

    // ---------------- drivers ----------------
    // One pixel tick: pxl_cen for one clock, then one free clock.
    task automatic tick();
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_pix(input logic hb, input logic vb, input logic [7:0] s1,
                           input logic [3:0] s2, input logic [6:0] ob);
        lhbl = hb; lvbl = vb; scr1_pxl = s1; scr2_pxl = s2; obj_pxl = ob;
    endtask

    task automatic cpu_access(input logic [10:0] addr, input logic wrn, input logic [7:0] wd,
                              output logic [7:0] rd, output logic ok);
        bus.cpu_addr = addr;
        bus.cpu_wrn  = wrn;
        bus.cpu_dout = wd;
        bus.pal_cs   = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk); #1;
            ok = bus.cpu_ok;
        end
        rd = bus.cpu_din;
        bus.pal_cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_write(input string name, input logic [10:0] addr, input logic [7:0] wd);
        logic [7:0] rd;
        logic ok;
        cpu_access(addr, 1'b0, wd, rd, ok);
        check({name, " cpu_ok"}, 32'(ok), 32'd1);
    endtask

    task automatic cpu_read_chk(input string name, input logic [10:0] addr, input logic [7:0] exp);
        logic [7:0] rd;
        logic ok;
        cpu_access(addr, 1'b1, 8'h00, rd, ok);
        check({name, " cpu_ok"}, 32'(ok), 32'd1);
        check({name, " cpu_din"}, 32'(rd), 32'(exp));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        hb;
        logic        vb;
        logic [7:0]  s1;
        logic [3:0]  s2;
        logic [6:0]  ob;
        logic [14:0] rgb;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        logic seen;

        // palette entries used below (index: R,G,B)
        //   0x085 obj 05     : 1F,00,10
        //   0x003 scr1 03    : 01,02,03
        //   0x107 scr2 7     : 0A,15,1E
        //   0x10F scr2 F     : 11,12,13
        vecs[0] = '{1'b1, 1'b1, 8'h00, 4'h7, 7'h00, {5'h0A, 5'h15, 5'h1E}};
        vecs[1] = '{1'b1, 1'b1, 8'h00, 4'h7, 7'h05, {5'h1F, 5'h00, 5'h10}};
        vecs[2] = '{1'b1, 1'b1, 8'h83, 4'h7, 7'h05, {5'h01, 5'h02, 5'h03}};
        vecs[3] = '{1'b1, 1'b1, 8'h03, 4'h7, 7'h05, {5'h1F, 5'h00, 5'h10}};
        vecs[4] = '{1'b1, 1'b1, 8'h03, 4'hF, 7'h00, {5'h01, 5'h02, 5'h03}};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 4'hF, 7'h10, {5'h11, 5'h12, 5'h13}};
        vecs[6] = '{1'b0, 1'b1, 8'h03, 4'h7, 7'h05, 15'h0000};
        vecs[7] = '{1'b1, 1'b0, 8'h03, 4'h7, 7'h05, 15'h0000};
        vecs[8] = '{1'b1, 1'b1, 8'h90, 4'h7, 7'h00, {5'h0A, 5'h15, 5'h1E}};
        vecs[9] = '{1'b1, 1'b1, 8'h83, 4'hF, 7'h00, {5'h01, 5'h02, 5'h03}};

        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        bus.pal_cs   = 1'b0;
        bus.cpu_wrn  = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("reset rgb", 32'(rgb_now()), 32'd0);
        check("reset LHBL", 32'(LHBL), 32'd0);
        check("reset LVBL", 32'(LVBL), 32'd0);
        check("reset cpu_ok", 32'(bus.cpu_ok), 32'd0);
        check("reset cpu_din", 32'(bus.cpu_din), 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- palette load and readback ----------------
        cpu_write("wr 085 R", 11'h085, 8'h1F);
        cpu_write("wr 085 G", 11'h285, 8'h00);
        cpu_write("wr 085 B", 11'h485, 8'hF0);   // only bits [4:0] stored -> 10
        cpu_write("wr 003 R", 11'h003, 8'h01);
        cpu_write("wr 003 G", 11'h203, 8'h02);
        cpu_write("wr 003 B", 11'h403, 8'h03);
        cpu_write("wr 107 R", 11'h107, 8'h0A);
        cpu_write("wr 107 G", 11'h307, 8'h15);
        cpu_write("wr 107 B", 11'h507, 8'h1E);
        cpu_write("wr 10F R", 11'h10F, 8'h11);
        cpu_write("wr 10F G", 11'h30F, 8'h12);
        cpu_write("wr 10F B", 11'h50F, 8'h13);
        cpu_write("wr bank3", 11'h685, 8'h1F);   // ignored
        cpu_read_chk("rd 085 R", 11'h085, 8'h1F);
        cpu_read_chk("rd 085 G", 11'h285, 8'h00);
        cpu_read_chk("rd 085 B", 11'h485, 8'h10);
        cpu_read_chk("rd 107 B", 11'h507, 8'h1E);
        cpu_read_chk("rd bank3", 11'h707, 8'h00);

        // ---------------- streamed priority table ----------------
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                set_pix(vecs[i].hb, vecs[i].vb, vecs[i].s1, vecs[i].s2, vecs[i].ob);
                exp_q.push_back({vecs[i].hb, vecs[i].vb, vecs[i].rgb});
            end
            tick();
            if (i >= 2) begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check($sformatf("vec%0d", i - 2), 32'({LHBL, LVBL, rgb_now()}), 32'(e));
            end
        end

        // ---------------- one-tick horizontal blank pulse ----------------
        set_pix(1'b1, 1'b1, 8'h00, 4'h7, 7'h00);
        repeat (3) tick();
        check("pulse pre rgb", 32'(rgb_now()), 32'({5'h0A, 5'h15, 5'h1E}));
        lhbl = 1'b0;
        tick();
        lhbl = 1'b1;
        check("pulse t0 LHBL", 32'(LHBL), 32'd1);
        tick();
        check("pulse t1 LHBL", 32'(LHBL), 32'd1);
        tick();
        check("pulse t2 LHBL", 32'(LHBL), 32'd0);
        check("pulse t2 rgb", 32'(rgb_now()), 32'd0);
        tick();
        check("pulse t3 LHBL", 32'(LHBL), 32'd1);
        check("pulse t3 rgb", 32'(rgb_now()), 32'({5'h0A, 5'h15, 5'h1E}));

        // ---------------- CPU reads between pixel ticks ----------------
        set_pix(1'b1, 1'b1, 8'h83, 4'h7, 7'h00);
        tick();
        cpu_read_chk("mid rd 10F R", 11'h10F, 8'h11);
        tick();
        cpu_read_chk("mid rd 10F G", 11'h30F, 8'h12);
        tick();
        check("mid rgb", 32'(rgb_now()), 32'({5'h01, 5'h02, 5'h03}));

        // ---------------- write held off by active video ----------------
        pxl_cen = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.cpu_addr = 11'h003;
        bus.cpu_wrn  = 1'b0;
        bus.cpu_dout = 8'h04;
        bus.pal_cs   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("busy ok c%0d", k), 32'(bus.cpu_ok), 32'd0);
            check($sformatf("busy rgb c%0d", k), 32'(rgb_now()), 32'({5'h01, 5'h02, 5'h03}));
        end
        lhbl = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3 && !seen; k++) begin
            @(posedge clk); #1;
            seen = bus.cpu_ok;
        end
        check("blank ok within 3", 32'(seen), 32'd1);
        bus.pal_cs = 1'b0;
        pxl_cen = 1'b0;
        lhbl = 1'b1;
        @(posedge clk); #1;
        cpu_read_chk("rd 003 R new", 11'h003, 8'h04);
        repeat (3) tick();
        check("new 003 shown", 32'(rgb_now()), 32'({5'h04, 5'h02, 5'h03}));

        // ---------------- reset during a pending write ----------------
        set_pix(1'b1, 1'b1, 8'h00, 4'h7, 7'h05);
        pxl_cen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.cpu_addr = 11'h085;
        bus.cpu_wrn  = 1'b0;
        bus.cpu_dout = 8'h00;
        bus.pal_cs   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stuck in WAIT", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst cpu_ok", 32'(bus.cpu_ok), 32'd0);
        check("rst state", 32'(dbg_state), 32'd0);
        check("rst rgb", 32'(rgb_now()), 32'd0);
        check("rst LHBL", 32'(LHBL), 32'd0);
        bus.pal_cs = 1'b0;
        pxl_cen = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst rgb", 32'(rgb_now()), 32'd0);
        check("post rst LVBL", 32'(LVBL), 32'd0);
        check("post rst cpu_ok", 32'(bus.cpu_ok), 32'd0);
        cpu_read_chk("rd 085 R kept", 11'h085, 8'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
